// File: rtl/fetch_icache.sv
// fetch_icache: direct-mapped instruction cache with a single outstanding
// line refill and a walking (one set per cycle) flush.
// Optional build macro ICACHE_STATS_EN adds saturating hit/miss counters.
module fetch_icache #(
  parameter int SETS  = 64,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [31:0]           address,
  input  logic                  flush,
  output logic [31:0]           instruction,
  output logic                  hit,
  output logic                  stall,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_valid,
  input  logic [32*WORDS-1:0]   mem_in
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int LOG_W = $clog2(WORDS);
  localparam int OFF_W = (LOG_W > 0) ? LOG_W : 1;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - LOG_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_e;

  state_e              state_q;
  logic                pend_q;
  logic [IDX_W-1:0]    fcnt_q;
  logic [SETS-1:0]     valid_q;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [32*WORDS-1:0] data_q [SETS];
  logic [31:0]         instr_q;
  logic [31:0]         maddr_q;
  logic                hit_q;
  logic                mreq_q;

  logic [OFF_W-1:0]    req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic [32*WORDS-1:0] req_line;
  logic                lookup_hit;
  logic                fill_done;

  // Split the request address, look up its set, and derive the stall.
  // The refill target comes from the registered line address, so the
  // write-back set never depends on the live address bus.
  always_comb begin
    req_off    = OFF_W'(address & 32'(WORDS - 1));
    req_idx    = IDX_W'(address >> LOG_W);
    req_tag    = TAG_W'(address >> (LOG_W + IDX_W));
    fill_idx   = IDX_W'(maddr_q >> LOG_W);
    fill_tag   = TAG_W'(maddr_q >> (LOG_W + IDX_W));
    req_line   = data_q[req_idx];
    lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    fill_done  = (state_q == REFILL) && mem_valid;
    case (state_q)
      IDLE:    stall = flush | (req & ~lookup_hit);
      default: stall = 1'b1;
    endcase
  end

  // Line storage: tag and data are only written when a refill lands.
  always_ff @(posedge clk) begin
    if (rst && fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_in;
    end
  end

  // Control FSM with registered response and refill-request outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      fcnt_q  <= '0;
      valid_q <= '0;
      instr_q <= '0;
      hit_q   <= 1'b0;
      mreq_q  <= 1'b0;
      maddr_q <= '0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush) begin
            state_q <= FLUSH;
            fcnt_q  <= '0;
          end else if (req) begin
            if (lookup_hit) begin
              hit_q   <= 1'b1;
              instr_q <= req_line[32*req_off +: 32];
            end else begin
              state_q <= REFILL;
              mreq_q  <= 1'b1;
              maddr_q <= address & ~32'(WORDS - 1);
            end
          end
        end
        REFILL: begin
          if (flush) pend_q <= 1'b1;
          if (mem_valid) begin
            valid_q[fill_idx] <= 1'b1;
            hit_q   <= 1'b1;
            instr_q <= mem_in[32*req_off +: 32];
            mreq_q  <= 1'b0;
            pend_q  <= 1'b0;
            fcnt_q  <= '0;
            state_q <= (pend_q || flush) ? FLUSH : IDLE;
          end
        end
        FLUSH: begin
          valid_q[fcnt_q] <= 1'b0;
          fcnt_q <= fcnt_q + IDX_W'(1);
          if (fcnt_q == IDX_W'(SETS - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instruction = instr_q;
  assign hit         = hit_q;
  assign mem_req     = mreq_q;
  assign mem_addr    = maddr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hcnt_q;
  logic [31:0] mcnt_q;
  logic        acc_hit;
  logic        acc_miss;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Classify accepted IDLE lookups for the statistics counters.
  always_comb begin
    acc_hit  = (state_q == IDLE) && !flush && req && lookup_hit;
    acc_miss = (state_q == IDLE) && !flush && req && !lookup_hit;
  end

  // Saturating counters; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (acc_hit)  hcnt_q <= sat_inc(hcnt_q);
      if (acc_miss) mcnt_q <= sat_inc(mcnt_q);
    end
  end

  assign hit_count  = hcnt_q;
  assign miss_count = mcnt_q;
`endif

endmodule
